fp_wb_arbiter: RTL and testbench

- Writeback-side responder for the floating-point units. It is the consumer end of unit_writeback_interface: it samples done/rd/id from each FP unit and returns ack.
- Arbitrates up to NUM_UNITS producers (MAC, div/sqrt, convert, ...) into one registered FP register-file write port.
- Provides back-pressure to the units via ack, and accepts back-pressure from the register file via wb_ready.

---
 rtl/fp_wb_pkg.sv | 25 ++
 rtl/fp_wb_arbiter_if.sv | 30 +++
 rtl/fp_wb_prio_select.sv | 35 +++
 rtl/fp_wb_arbiter.sv | 84 ++++++++
 tb/tb_fp_wb_arbiter.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/fp_wb_pkg.sv
// Shared types and sizing helpers for the FP writeback arbiter.
// Build option: FP_WB_ROUND_ROBIN_EN selects rotating priority in fp_wb_arbiter.
package fp_wb_pkg;

    localparam int FP_WB_NUM_UNITS = 3;
    localparam int FP_WB_ID_W      = 3;
    localparam int FP_WB_DATA_W    = 34;

    // Source-index width; a lone unit still needs one bit to name it.
    function automatic int fp_wb_src_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int FP_WB_SRC_W = fp_wb_src_w(FP_WB_NUM_UNITS);

    typedef logic [FP_WB_DATA_W-1:0] flopoco_t;
    typedef logic [FP_WB_ID_W-1:0]   id_t;

    typedef struct packed {
        flopoco_t               data;
        id_t                    id;
        logic [FP_WB_SRC_W-1:0] src;
    } fp_wb_result_t;

endpackage

// File: rtl/fp_wb_arbiter_if.sv
// Writeback bus between the FP units / register file and the arbiter.
// The slave modport is the arbiter side; master is the surrounding environment.
interface fp_wb_arbiter_if #(
    parameter int NUM_UNITS = 3,
    parameter int ID_W      = 3,
    parameter int DATA_W    = 34
);
    localparam int SRC_W = fp_wb_pkg::fp_wb_src_w(NUM_UNITS);

    logic [NUM_UNITS-1:0]             unit_done;
    logic [NUM_UNITS-1:0][DATA_W-1:0] unit_rd;
    logic [NUM_UNITS-1:0][ID_W-1:0]   unit_id;
    logic [NUM_UNITS-1:0]             unit_ack;
    logic                             wb_valid;
    logic [ID_W-1:0]                  wb_id;
    logic [DATA_W-1:0]                wb_data;
    logic [SRC_W-1:0]                 wb_src;
    logic                             wb_ready;

    modport slave (
        input  unit_done, unit_rd, unit_id, wb_ready,
        output unit_ack, wb_valid, wb_id, wb_data, wb_src
    );

    modport master (
        output unit_done, unit_rd, unit_id, wb_ready,
        input  unit_ack, wb_valid, wb_id, wb_data, wb_src
    );

endinterface

// File: rtl/fp_wb_prio_select.sv
// Combinational one-hot picker: first asserted request at or after i_start,
// wrapping modulo N. With i_start tied to 0 it is plain lowest-index-wins.
module fp_wb_prio_select #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_start,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    int               w_pos;
    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_pos  = 0;
        w_cand = '0;
        for (int i = 0; i < N; i++) begin
            w_pos = int'(i_start) + i;
            if (w_pos >= N) w_pos = w_pos - N;
            w_cand = IDX_W'(w_pos);
            if (!o_any && i_req[w_cand]) begin
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
                o_any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_wb_arbiter.sv
// FP writeback arbiter: acks one done unit per cycle into a registered RF write port.
// Build option: FP_WB_ROUND_ROBIN_EN (rotating priority); default is fixed, index 0 highest.
module fp_wb_arbiter
    import fp_wb_pkg::*;
#(
    parameter int NUM_UNITS = FP_WB_NUM_UNITS,
    parameter int ID_W      = FP_WB_ID_W,
    parameter int DATA_W    = FP_WB_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    fp_wb_arbiter_if.slave        bus
);

    localparam int SRC_W = fp_wb_src_w(NUM_UNITS);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ID_W-1:0]   id;
        logic [SRC_W-1:0]  src;
    } result_t;

    result_t              r_out;
    logic                 r_valid;
    logic [SRC_W-1:0]     w_start;
    logic [SRC_W-1:0]     w_idx;
    logic [NUM_UNITS-1:0] w_gnt;
    logic                 w_any;
    logic                 w_out_free;
    logic                 w_grant;

`ifdef FP_WB_ROUND_ROBIN_EN
    logic [SRC_W-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (!rst)
            r_ptr <= '0;
        else if (w_grant)
            r_ptr <= (w_idx == SRC_W'(NUM_UNITS - 1)) ? '0 : w_idx + 1'b1;
    end

    assign w_start = r_ptr;
`else
    assign w_start = '0;
`endif

    fp_wb_prio_select #(
        .N     (NUM_UNITS),
        .IDX_W (SRC_W)
    ) u_sel (
        .i_req   (bus.unit_done),
        .i_start (w_start),
        .o_gnt   (w_gnt),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // A slot frees up in the same cycle the register file takes the current result.
    assign w_out_free   = !r_valid || bus.wb_ready;
    assign w_grant      = rst && w_out_free && w_any;
    assign bus.unit_ack = w_grant ? w_gnt : '0;

    // NOTE: reset is synchronous (sampled on the edge), and all state uses <= so
    // every flop sees pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_out   <= '0;
        end else if (w_grant) begin
            r_valid    <= 1'b1;
            r_out.data <= bus.unit_rd[w_idx];
            r_out.id   <= bus.unit_id[w_idx];
            r_out.src  <= w_idx;
        end else if (bus.wb_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.wb_valid = r_valid;
    assign bus.wb_data  = r_out.data;
    assign bus.wb_id    = r_out.id;
    assign bus.wb_src   = r_out.src;

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Self-checking bench for fp_wb_arbiter: per-unit pending queues drive the bus,
// a reference arbiter pushes expected results to a scoreboard popped on each load.
module tb_fp_wb_arbiter;
    import fp_wb_pkg::*;

    localparam int N = FP_WB_NUM_UNITS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_wb_arbiter_if #(.NUM_UNITS(N), .ID_W(FP_WB_ID_W), .DATA_W(FP_WB_DATA_W)) bus ();

    fp_wb_arbiter #(.NUM_UNITS(N), .ID_W(FP_WB_ID_W), .DATA_W(FP_WB_DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    fp_wb_result_t uq [N][$];
    fp_wb_result_t sb [$];
    fp_wb_result_t m_out;
    logic          m_valid;
    int            m_ptr;
    int            ack_count;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int model_winner(input logic [N-1:0] req);
        int j;
        for (int k = 0; k < N; k++) begin
`ifdef FP_WB_ROUND_ROBIN_EN
            j = (m_ptr + k) % N;
`else
            j = k;
`endif
            if (req[j]) return j;
        end
        return -1;
    endfunction

    task automatic push_item(input int u, input logic [FP_WB_DATA_W-1:0] d, input int id);
        fp_wb_result_t e;
        e.data = d;
        e.id   = FP_WB_ID_W'(id);
        e.src  = '0;
        uq[u].push_back(e);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.unit_done[i] = (uq[i].size() > 0);
            bus.unit_rd[i]   = (uq[i].size() > 0) ? uq[i][0].data : '0;
            bus.unit_id[i]   = (uq[i].size() > 0) ? uq[i][0].id   : '0;
        end
    endtask

    // One clock: check ack mid-cycle, then check the output register after the edge.
    task automatic cycle();
        logic [N-1:0]  req;
        logic [N-1:0]  exp_ack;
        fp_wb_result_t e;
        int            w;
        bit            granted;
        drive();
        @(negedge clk);
        for (int i = 0; i < N; i++) req[i] = (uq[i].size() > 0);
        exp_ack = '0;
        granted = 1'b0;
        if (rst && (!m_valid || bus.wb_ready)) begin
            w = model_winner(req);
            if (w >= 0) begin
                exp_ack[w] = 1'b1;
                granted    = 1'b1;
                e          = uq[w][0];
                e.src      = FP_WB_SRC_W'(w);
                sb.push_back(e);
                void'(uq[w].pop_front());
                m_ptr = (w + 1) % N;
                ack_count++;
            end
        end
        check("unit_ack", 64'(bus.unit_ack), 64'(exp_ack));
        @(posedge clk);
        #1;
        if (!rst) begin
            m_valid = 1'b0;
            m_ptr   = 0;
        end else if (granted) begin
            m_out   = sb.pop_front();
            m_valid = 1'b1;
        end else if (bus.wb_ready) begin
            m_valid = 1'b0;
        end
        check("wb_valid", 64'(bus.wb_valid), 64'(m_valid));
        if (m_valid) begin
            check("wb_data", 64'(bus.wb_data), 64'(m_out.data));
            check("wb_id",   64'(bus.wb_id),   64'(m_out.id));
            check("wb_src",  64'(bus.wb_src),  64'(m_out.src));
        end
        drive();
    endtask

    initial begin
        m_valid      = 1'b0;
        m_ptr        = 0;
        ack_count    = 0;
        rst          = 1'b0;
        bus.wb_ready = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(bus.wb_valid), 64'd0);
        check("rst_data",  64'(bus.wb_data),  64'd0);
        check("rst_id",    64'(bus.wb_id),    64'd0);
        check("rst_src",   64'(bus.wb_src),   64'd0);
        check("rst_ack",   64'(bus.unit_ack), 64'd0);
        rst = 1'b1;

        // Single unit
        bus.wb_ready = 1'b1;
        push_item(1, 34'h0_3F80_0000, 5);
        cycle();
        check("single_data", 64'(bus.wb_data), 64'h0_3F80_0000);
        check("single_id",   64'(bus.wb_id),   64'd5);
        check("single_src",  64'(bus.wb_src),  64'd1);
        cycle();

        // Stall: output held four cycles while unit 0 waits
        push_item(2, 34'h1_4000_0001, 6);
        cycle();
        bus.wb_ready = 1'b0;
        push_item(0, 34'h0_C0A0_0000, 7);
        repeat (4) cycle();
        check("stall_held_id", 64'(bus.wb_id), 64'd6);
        bus.wb_ready = 1'b1;
        cycle();
        check("stall_release_src", 64'(bus.wb_src), 64'd0);
        cycle();

        // Contention: unit 0 holds three results, units 1 and 2 one each
        push_item(0, 34'h0_0000_0010, 1);
        push_item(0, 34'h0_0000_0011, 1);
        push_item(0, 34'h0_0000_0012, 1);
        push_item(1, 34'h0_0000_0020, 2);
        push_item(2, 34'h0_0000_0030, 3);
        repeat (5) cycle();
        cycle();

        // Reset mid-flight with every unit requesting
        push_item(2, 34'h2_1234_5678, 4);
        cycle();
        bus.wb_ready = 1'b0;
        push_item(0, 34'h0_0000_0A00, 1);
        push_item(1, 34'h0_0000_0B00, 2);
        push_item(2, 34'h0_0000_0C00, 3);
        cycle();
        rst = 1'b0;
        cycle();
        rst          = 1'b1;
        bus.wb_ready = 1'b1;
        cycle();
        check("post_rst_src", 64'(bus.wb_src), 64'd0);
        repeat (3) cycle();

        // Throughput: eight back-to-back results from unit 2
        ack_count = 0;
        for (int k = 0; k < 8; k++) push_item(2, 34'(64'h0_1000_0000 + k), k);
        repeat (8) cycle();
        check("tput_acks", 64'(ack_count), 64'd8);
        cycle();
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
